lb_arbiter: RTL
===============

# lb_arbiter

Two-requester arbiter and sequencer for the 32-bit Mesa local bus. Port 0 is the host path (mesa2lb output); port 1 is an on-chip requester (PROM loader, self-test). Each port's single-cycle write/read pulse is captured into a one-entry holding register. Captured requests are granted round-robin and replayed onto the shared lb_* bus, and read data is routed back to the owner. A missing lb_rd_rdy is cut off by a timeout, which returns an error word instead.

## Interface
- TIMEOUT_CYC, 255: cycles in WAIT_RD before a read is forced complete; legal range 8..65535.
- RD_ERR_DATA, 32'hDEADBEEF: data returned on a timed-out read.

- clk_lb  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mN_wr, mN_rd (N=0,1)  in  1 each  single-cycle request pulses.
- mN_addr, mN_wr_d  in  32 each  sampled in the cycle of the pulse.
- mN_busy  out  1  request held or in flight; new pulses are ignored while high.
- mN_rd_d  out  32  read return data, valid with mN_rd_rdy.
- mN_rd_rdy  out  1  single-cycle read completion pulse.
- lb_wr, lb_rd  out  1 each  single-cycle bus strobes.
- lb_addr, lb_wr_d  out  32 each  held from issue until the next issue.
- lb_rd_d  in  32  bus read data.
- lb_rd_rdy  in  1  bus read data valid.
- timeout_err  out  1  one-cycle pulse when a read times out.
- grant_id  out  1  port owning the current or last bus transaction.

## Operation
- Capture: a pulse with mN_busy=0 latches op, addr and data, and sets busy the next cycle.
  - mN_wr and mN_rd together: treated as write only.
  - Pulse while busy: dropped silently.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any port is pending, grant it and go to ISSUE.
  - If both are pending, grant the port that is not last_grant.
  - last_grant resets to 1, so port 0 wins the first tie.
- ISSUE:
  - Register lb_addr, lb_wr_d, grant_id and one strobe.
  - Write: clear the owner's pending flag and return to IDLE.
  - Read: clear the counter and go to WAIT_RD.
- WAIT_RD:
  - On lb_rd_rdy: capture lb_rd_d into mN_rd_d of the owner, pulse mN_rd_rdy, clear pending, go to IDLE.
  - Counter reaches TIMEOUT_CYC with no rdy: return RD_ERR_DATA, pulse mN_rd_rdy and timeout_err, go to IDLE.
  - lb_rd_rdy in the same cycle as the terminal count: the real data wins and timeout_err stays low.
- lb_rd_rdy outside WAIT_RD, including late data after a timeout: ignored.
- The non-granted port can capture a new request at any time while its own busy is low.
- Counter: 16 bits; saturates and does not wrap.

## Timing
- Reset values: all outputs 0; state IDLE; pending flags 0; counter 0; last_grant 1.
- Reset asserted mid-transaction: the transaction is abandoned and no completion pulse is issued.
- Write, pulse in cycle 0 with the bus idle:
  - busy=1 in cycle 1.
  - lb_wr=1 in cycle 2 with lb_addr/lb_wr_d valid.
  - busy=0 in cycle 3.
- Read, pulse in cycle 0:
  - lb_rd=1 in cycle 2.
  - lb_rd_rdy is sampled from cycle 3 on.
  - If rdy arrives in cycle k, mN_rd_rdy=1 and busy=0 in cycle k+1.
- Timeout, lb_rd in cycle 2 and no rdy:
  - mN_rd_rdy and timeout_err in cycle 3+TIMEOUT_CYC.
  - busy=0 in the same cycle.
- Back-to-back: the next grant is made in the first IDLE cycle, giving a minimum of 2 cycles between lb strobes.
- Maximum wait for a pending request: one full transaction of the other port.

## Structure
- Shared package mesa_lb_pkg holds:
  - FSM state encodings (2 bits);
  - counter width constant (16);
  - default RD_ERR_DATA.
- Sub-module lb_arb_port: one-entry holding register (capture, pending, busy, clear-on-done). It is instantiated twice.
- FSM, round-robin pointer, timeout counter and return mux live in the top level.

## Test plan
- Port 0 write, addr 0x0000_0010, data 0x1234_5678 -> lb_wr in cycle 2 with those values; m0_busy high for cycles 1-2 only.
- Both ports pulse a read in the same cycle; responder returns 0xA5A5_0001 then 0xA5A5_0002 -> port 0 is issued first and gets 0xA5A5_0001; port 1 gets 0xA5A5_0002; grant_id goes 0 then 1.
- Port 1 read, responder silent, TIMEOUT_CYC=16 -> m1_rd_rdy with 0xDEADBEEF and timeout_err in cycle 19; a late lb_rd_rdy in cycle 25 causes no pulse.
- Port 0 issues a second pulse while busy -> exactly one lb strobe on the bus.
- Reset asserted in WAIT_RD -> all outputs 0 immediately; no mN_rd_rdy; after release, the next tie grants port 0.
- lb_rd_rdy in the same cycle as the terminal count -> real data returned and timeout_err stays 0.

Source files
------------

// File: rtl/mesa_lb_pkg.sv
// Shared constants and types for the Mesa local-bus arbiter slice.
package mesa_lb_pkg;

  localparam int unsigned LB_DW = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;

  localparam logic [LB_DW-1:0] RD_ERR_DATA_DEF = 32'hDEADBEEF;

  typedef struct packed {
    logic             wr;
    logic [LB_DW-1:0] addr;
    logic [LB_DW-1:0] data;
  } lb_req_t;

endpackage

// File: rtl/lb_arb_port.sv
// One-entry holding register for a single requester; busy covers capture through completion.
module lb_arb_port
  import mesa_lb_pkg::*;
(
  input  logic             clk_lb,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [LB_DW-1:0] addr,
  input  logic [LB_DW-1:0] wr_d,
  input  logic             clr,
  output logic             busy,
  output lb_req_t          req
);

  // A simultaneous wr+rd is stored as a write; pulses while busy are dropped.
  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      req  <= '0;
    end else if (clr) begin
      busy <= 1'b0;
    end else if (!busy && (wr || rd)) begin
      busy     <= 1'b1;
      req.wr   <= wr;
      req.addr <= addr;
      req.data <= wr_d;
    end
  end

endmodule

// File: rtl/lb_arbiter.sv
// Two-port round-robin arbiter that replays captured requests onto the Mesa local bus
// and routes read data (or a timeout error word) back to the owning port.
module lb_arbiter
  import mesa_lb_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYC = 255,
  parameter logic [LB_DW-1:0] RD_ERR_DATA = RD_ERR_DATA_DEF
) (
  input  logic             clk_lb,
  input  logic             reset,
  input  logic             m0_wr,
  input  logic             m0_rd,
  input  logic [LB_DW-1:0] m0_addr,
  input  logic [LB_DW-1:0] m0_wr_d,
  output logic             m0_busy,
  output logic [LB_DW-1:0] m0_rd_d,
  output logic             m0_rd_rdy,
  input  logic             m1_wr,
  input  logic             m1_rd,
  input  logic [LB_DW-1:0] m1_addr,
  input  logic [LB_DW-1:0] m1_wr_d,
  output logic             m1_busy,
  output logic [LB_DW-1:0] m1_rd_d,
  output logic             m1_rd_rdy,
  output logic             lb_wr,
  output logic             lb_rd,
  output logic [LB_DW-1:0] lb_addr,
  output logic [LB_DW-1:0] lb_wr_d,
  input  logic [LB_DW-1:0] lb_rd_d,
  input  logic             lb_rd_rdy,
  output logic             timeout_err,
  output logic             grant_id
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);

  lb_req_t          req0, req1, sel_req;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             grant_c, issue_c, done_c, tmo_c;
  logic             own_wr_c, rd_fin_c, clr0_c, clr1_c;
  logic [LB_DW-1:0] rd_data_c;

  lb_arb_port u_port0 (
    .clk_lb (clk_lb),
    .reset  (reset),
    .wr     (m0_wr),
    .rd     (m0_rd),
    .addr   (m0_addr),
    .wr_d   (m0_wr_d),
    .clr    (clr0_c),
    .busy   (m0_busy),
    .req    (req0)
  );

  lb_arb_port u_port1 (
    .clk_lb (clk_lb),
    .reset  (reset),
    .wr     (m1_wr),
    .rd     (m1_rd),
    .addr   (m1_addr),
    .wr_d   (m1_wr_d),
    .clr    (clr1_c),
    .busy   (m1_busy),
    .req    (req1)
  );

  assign sel_req   = grant_c ? req1 : req0;
  assign own_wr_c  = grant_id ? req1.wr : req0.wr;
  assign clr0_c    = done_c && !grant_id;
  assign clr1_c    = done_c && grant_id;
  assign rd_fin_c  = done_c && (state == ST_WAIT_RD);
  assign rd_data_c = lb_rd_rdy ? lb_rd_d : RD_ERR_DATA;

  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Strobes are registered on the IDLE->ISSUE edge so they are visible during ISSUE.
  always_comb begin
    state_nxt = state;
    grant_c   = last_grant;
    issue_c   = 1'b0;
    done_c    = 1'b0;
    tmo_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m0_busy || m1_busy) begin
          issue_c   = 1'b1;
          grant_c   = (m0_busy && m1_busy) ? !last_grant : m1_busy;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (own_wr_c) begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (lb_rd_rdy) begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == TERM_CNT) begin
          done_c    = 1'b1;
          tmo_c     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs, return mux, round-robin pointer and saturating wait counter.
  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      lb_wr       <= 1'b0;
      lb_rd       <= 1'b0;
      lb_addr     <= '0;
      lb_wr_d     <= '0;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      m0_rd_d     <= '0;
      m1_rd_d     <= '0;
      m0_rd_rdy   <= 1'b0;
      m1_rd_rdy   <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      lb_wr       <= 1'b0;
      lb_rd       <= 1'b0;
      m0_rd_rdy   <= 1'b0;
      m1_rd_rdy   <= 1'b0;
      timeout_err <= tmo_c;
      if (issue_c) begin
        grant_id   <= grant_c;
        last_grant <= grant_c;
        lb_addr    <= sel_req.addr;
        lb_wr_d    <= sel_req.data;
        lb_wr      <= sel_req.wr;
        lb_rd      <= !sel_req.wr;
      end
      if (state == ST_ISSUE) begin
        cnt <= '0;
      end else if (state == ST_WAIT_RD && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (rd_fin_c) begin
        if (grant_id) begin
          m1_rd_d   <= rd_data_c;
          m1_rd_rdy <= 1'b1;
        end else begin
          m0_rd_d   <= rd_data_c;
          m0_rd_rdy <= 1'b1;
        end
      end
    end
  end

endmodule
